// File: rtl/global_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : global_pkg
//  Description : Shared types and constants for the ALU and its control unit.
//  Revision    : 1.0 - initial release with cpu_ctrl support
// ============================================================================
package global_pkg;

   typedef enum logic [4:0] {
      nop      = 5'd0,
      op_lda   = 5'd1,
      op_ldb   = 5'd2,
      op_add   = 5'd3,
      op_sub   = 5'd4,
      op_and   = 5'd5,
      op_or    = 5'd6,
      op_xor   = 5'd7,
      op_not   = 5'd8,
      op_shl   = 5'd9,
      op_shr   = 5'd10,
      op_oeacc = 5'd11
   } alu_op;

   localparam logic [4:0] c_alu_op_last = 5'd11;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_DECODE   = 3'd2,
      ST_EXEC     = 3'd3,
      ST_FETCH_T  = 3'd4,
      ST_DECODE_T = 3'd5,
      ST_HALT     = 3'd6
   } ctrl_state_t;

   localparam logic [1:0] INS_ALU = 2'b00;
   localparam logic [1:0] INS_LDI = 2'b01;
   localparam logic [1:0] INS_JMP = 2'b10;
   localparam logic [1:0] INS_HLT = 2'b11;

   localparam logic [1:0] COND_ALWAYS = 2'b00;
   localparam logic [1:0] COND_Z      = 2'b01;
   localparam logic [1:0] COND_C      = 2'b10;
   localparam logic [1:0] COND_N      = 2'b11;

   function automatic logic is_alu_code(input logic [4:0] code);
      return code <= c_alu_op_last;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl
//  Description : Fetch/decode/execute sequencer driving the ALU from ROM code.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_ctrl
   import global_pkg::*;
#(
   parameter int PC_W    = 12,
   parameter int ROM_LAT = 1
)(
   input  logic            Clk,
   input  logic            Rst,
   input  logic            Start,
   output logic [PC_W-1:0] ROM_addr,
   input  logic [11:0]     ROM_data,
   output alu_op           ALU_op,
   output logic [7:0]      InData,
   input  logic            FlagZ,
   input  logic            FlagC,
   input  logic            FlagN,
   input  logic            FlagE,
   output logic            Busy,
   output logic            Halted,
   output logic            Illegal
);

   localparam logic [PC_W-1:0] c_pc_one = PC_W'(1);

   ctrl_state_t     r_state, w_state_next;
   logic [PC_W-1:0] r_pc, w_pc_next;
   logic [1:0]      r_ir_cond, w_ir_cond_next;
   logic [PC_W-1:0] r_rom_addr, w_rom_addr_next;
   alu_op           r_alu_op, w_alu_op_next;
   logic [7:0]      r_indata, w_indata_next;
   logic            r_busy, w_busy_next;
   logic            r_halted, w_halted_next;
   logic            r_illegal, w_illegal_next;

   function automatic logic f_cond_met(input logic [1:0] cond, input logic z,
                                       input logic c, input logic n);
      case (cond)
         COND_Z:  return z;
         COND_C:  return c;
         COND_N:  return n;
         default: return 1'b1;
      endcase
   endfunction

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state    <= ST_IDLE;
         r_pc       <= '0;
         r_ir_cond  <= '0;
         r_rom_addr <= '0;
         r_alu_op   <= nop;
         r_indata   <= '0;
         r_busy     <= 1'b0;
         r_halted   <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_pc       <= w_pc_next;
         r_ir_cond  <= w_ir_cond_next;
         r_rom_addr <= w_rom_addr_next;
         r_alu_op   <= w_alu_op_next;
         r_indata   <= w_indata_next;
         r_busy     <= w_busy_next;
         r_halted   <= w_halted_next;
         r_illegal  <= w_illegal_next;
      end
   end

   // Outputs are registered from next-state values, so each appears in the
   // same cycle as the state it belongs to.
   always_comb begin
      w_state_next   = r_state;
      w_pc_next      = r_pc;
      w_ir_cond_next = r_ir_cond;
      w_alu_op_next  = nop;
      w_indata_next  = r_indata;
      w_illegal_next = r_illegal;

      case (r_state)
         ST_IDLE: begin
            if (Start) begin
               w_state_next   = ST_FETCH;
               w_pc_next      = '0;
               w_illegal_next = 1'b0;
            end
         end
         ST_HALT: begin
            // PC already points past the HLT word, so execution resumes there.
            if (Start) begin
               w_state_next   = ST_FETCH;
               w_illegal_next = 1'b0;
            end
         end
         ST_FETCH: begin
            w_pc_next    = r_pc + c_pc_one;
            w_state_next = ST_DECODE;
         end
         ST_DECODE: begin
            w_ir_cond_next = ROM_data[9:8];
            case (ROM_data[11:10])
               INS_ALU: begin
                  w_state_next  = ST_EXEC;
                  w_indata_next = 8'h00;
                  if (is_alu_code(ROM_data[4:0])) begin
                     w_alu_op_next = alu_op'(ROM_data[4:0]);
                  end else begin
                     w_illegal_next = 1'b1;
                  end
               end
               INS_LDI: begin
                  w_state_next  = ST_EXEC;
                  w_alu_op_next = ROM_data[8] ? op_ldb : op_lda;
                  w_indata_next = ROM_data[7:0];
               end
               INS_JMP: w_state_next = ST_FETCH_T;
               default: w_state_next = ST_HALT;
            endcase
         end
         ST_EXEC: begin
            w_state_next = ST_FETCH;
         end
         ST_FETCH_T: begin
            w_pc_next    = r_pc + c_pc_one;
            w_state_next = ST_DECODE_T;
         end
         ST_DECODE_T: begin
            if (f_cond_met(r_ir_cond, FlagZ, FlagC, FlagN)) begin
               w_pc_next = ROM_data[PC_W-1:0];
            end
            w_state_next = ST_FETCH;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

      w_rom_addr_next = r_rom_addr;
      if (w_state_next == ST_FETCH || w_state_next == ST_FETCH_T) begin
         w_rom_addr_next = w_pc_next;
      end
      w_busy_next   = (w_state_next != ST_IDLE) && (w_state_next != ST_HALT);
      w_halted_next = (w_state_next == ST_HALT);
   end

   assign ROM_addr = r_rom_addr;
   assign ALU_op   = r_alu_op;
   assign InData   = r_indata;
   assign Busy     = r_busy;
   assign Halted   = r_halted;
   assign Illegal  = r_illegal;

   logic w_unused;
   assign w_unused = &{1'b0, FlagE, (ROM_LAT == 1)};

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_ctrl
//  Description : Directed bench for cpu_ctrl with a behavioural ROM and ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_ctrl;
   import global_pkg::*;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Start;
   logic [11:0] ROM_addr;
   logic [11:0] ROM_data;
   alu_op       ALU_op;
   logic [7:0]  InData;
   logic        FlagZ = 1'b0;
   logic        FlagC = 1'b0;
   logic        FlagN = 1'b0;
   logic        FlagE;
   logic        Busy, Halted, Illegal;

   int checks = 0;
   int errors = 0;

   cpu_ctrl #(.PC_W(12), .ROM_LAT(1)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start),
      .ROM_addr(ROM_addr), .ROM_data(ROM_data),
      .ALU_op(ALU_op), .InData(InData),
      .FlagZ(FlagZ), .FlagC(FlagC), .FlagN(FlagN), .FlagE(FlagE),
      .Busy(Busy), .Halted(Halted), .Illegal(Illegal)
   );

   always #5 Clk = ~Clk;

   logic [11:0] rom [0:4095];
   always @(posedge Clk) ROM_data <= rom[ROM_addr];

   // Minimal ALU: flags are registered on the EXEC edge
   logic [7:0] ra = 8'h00, rb = 8'h00, racc = 8'h00, out_data = 8'h00;
   assign FlagE = 1'b0;
   always @(posedge Clk) begin : alu_model
      logic [8:0] res;
      res = 9'd0;
      if (ALU_op == op_add || ALU_op == op_sub) begin
         res = (ALU_op == op_add) ? ({1'b0, ra} + {1'b0, rb}) : ({1'b0, ra} - {1'b0, rb});
         racc  <= res[7:0];
         FlagC <= res[8];
         FlagZ <= (res[7:0] == 8'h00);
         FlagN <= res[7];
      end
      if (ALU_op == op_lda)   ra       <= InData;
      if (ALU_op == op_ldb)   rb       <= InData;
      if (ALU_op == op_oeacc) out_data <= racc;
   end

   typedef struct {
      logic [11:0] addr;
      alu_op       op;
      logic [7:0]  ind;
      logic        busy;
      logic        halted;
   } vec_t;

   vec_t tbl [15];

   function automatic vec_t mk(input logic [11:0] a, input alu_op o, input logic [7:0] d,
                               input logic b, input logic h);
      vec_t v;
      v.addr = a; v.op = o; v.ind = d; v.busy = b; v.halted = h;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge Clk);
   endtask

   // Leaves the bench at the negedge right after the edge that accepted Start
   task automatic run_start();
      @(negedge Clk);
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 4096; i++) rom[i] = 12'hC00;
   endtask

   task automatic jmp_test(input logic [7:0] a_val, input logic [11:0] exp_addr, input string tag);
      clear_rom();
      rom[0] = 12'h400 | {4'h0, a_val};
      rom[1] = 12'h505;
      rom[2] = 12'h004;
      rom[3] = 12'h900;
      rom[4] = 12'h020;
      do_reset();
      run_start();
      step(13);
      chk({tag, "_fetch_after_jmp"}, 32'(ROM_addr), 32'(exp_addr));
      chk({tag, "_busy"}, 32'(Busy), 32'd1);
      step(2);
      chk({tag, "_halted"}, 32'(Halted), 32'd1);
   endtask

   initial begin
      Rst   = 1'b1;
      Start = 1'b0;
      clear_rom();

      tbl[0]  = mk(12'h000, nop,      8'h00, 1'b1, 1'b0);
      tbl[1]  = mk(12'h000, nop,      8'h00, 1'b1, 1'b0);
      tbl[2]  = mk(12'h000, op_lda,   8'h03, 1'b1, 1'b0);
      tbl[3]  = mk(12'h001, nop,      8'h03, 1'b1, 1'b0);
      tbl[4]  = mk(12'h001, nop,      8'h03, 1'b1, 1'b0);
      tbl[5]  = mk(12'h001, op_ldb,   8'h02, 1'b1, 1'b0);
      tbl[6]  = mk(12'h002, nop,      8'h02, 1'b1, 1'b0);
      tbl[7]  = mk(12'h002, nop,      8'h02, 1'b1, 1'b0);
      tbl[8]  = mk(12'h002, op_add,   8'h00, 1'b1, 1'b0);
      tbl[9]  = mk(12'h003, nop,      8'h00, 1'b1, 1'b0);
      tbl[10] = mk(12'h003, nop,      8'h00, 1'b1, 1'b0);
      tbl[11] = mk(12'h003, op_oeacc, 8'h00, 1'b1, 1'b0);
      tbl[12] = mk(12'h004, nop,      8'h00, 1'b1, 1'b0);
      tbl[13] = mk(12'h004, nop,      8'h00, 1'b1, 1'b0);
      tbl[14] = mk(12'h004, nop,      8'h00, 1'b0, 1'b1);

      // Reset state
      step(2);
      chk("rst_rom_addr", 32'(ROM_addr), 32'h0);
      chk("rst_alu_op",   32'(ALU_op),   32'(nop));
      chk("rst_indata",   32'(InData),   32'h0);
      chk("rst_busy",     32'(Busy),     32'd0);
      chk("rst_halted",   32'(Halted),   32'd0);
      chk("rst_illegal",  32'(Illegal),  32'd0);
      Rst = 1'b0;

      // LDI A 3, LDI B 2, ADD, OEACC, HLT: cycle-by-cycle table
      rom[0] = 12'h403;
      rom[1] = 12'h502;
      rom[2] = 12'h003;
      rom[3] = 12'h00B;
      rom[4] = 12'hC00;
      run_start();
      for (int k = 0; k < 15; k++) begin
         if (k > 0) @(negedge Clk);
         chk($sformatf("p1_addr_k%0d", k),   32'(ROM_addr), 32'(tbl[k].addr));
         chk($sformatf("p1_op_k%0d", k),     32'(ALU_op),   32'(tbl[k].op));
         chk($sformatf("p1_indata_k%0d", k), 32'(InData),   32'(tbl[k].ind));
         chk($sformatf("p1_busy_k%0d", k),   32'(Busy),     32'(tbl[k].busy));
         chk($sformatf("p1_halted_k%0d", k), 32'(Halted),   32'(tbl[k].halted));
      end
      chk("p1_alu_outdata", 32'(out_data), 32'h05);

      // Asynchronous reset in the middle of the ADD execute cycle
      do_reset();
      run_start();
      step(8);
      chk("rstmid_op_before", 32'(ALU_op), 32'(op_add));
      #2 Rst = 1'b1;
      #1;
      chk("rstmid_op",      32'(ALU_op),   32'(nop));
      chk("rstmid_addr",    32'(ROM_addr), 32'h0);
      chk("rstmid_busy",    32'(Busy),     32'd0);
      chk("rstmid_indata",  32'(InData),   32'h0);
      @(negedge Clk);
      Rst = 1'b0;
      run_start();
      chk("rstmid_refetch_addr", 32'(ROM_addr), 32'h0);
      step(2);
      chk("rstmid_refetch_op",   32'(ALU_op),   32'(op_lda));
      chk("rstmid_refetch_data", 32'(InData),   32'h03);

      // Conditional jump on Z, taken then not taken
      jmp_test(8'h05, 12'h020, "jmpz_taken");
      jmp_test(8'h06, 12'h005, "jmpz_not");

      // Undefined ALU code is sticky until Start from HALT
      clear_rom();
      rom[0] = 12'h01F;
      rom[1] = 12'h407;
      rom[2] = 12'hC00;
      rom[3] = 12'h501;
      rom[4] = 12'hC00;
      do_reset();
      run_start();
      step(2);
      chk("ill_op_nop",    32'(ALU_op),  32'(nop));
      chk("ill_flag_set",  32'(Illegal), 32'd1);
      step(3);
      chk("ill_next_op",   32'(ALU_op),  32'(op_lda));
      chk("ill_sticky",    32'(Illegal), 32'd1);
      step(3);
      chk("ill_halted",    32'(Halted),  32'd1);
      chk("ill_sticky_h",  32'(Illegal), 32'd1);
      run_start();
      chk("ill_cleared",   32'(Illegal),  32'd0);
      chk("resume_addr",   32'(ROM_addr), 32'h003);
      chk("resume_halted", 32'(Halted),   32'd0);
      step(2);
      chk("resume_op",     32'(ALU_op),   32'(op_ldb));
      chk("resume_indata", 32'(InData),   32'h01);

      // PC wrap from 0xFFF to 0x000, with a Start pulse while busy
      clear_rom();
      rom[0]      = 12'h800;
      rom[1]      = 12'hFFE;
      rom[12'hFFE] = 12'h401;
      rom[12'hFFF] = 12'h402;
      do_reset();
      run_start();
      step(4);
      chk("wrap_fetch_ffe", 32'(ROM_addr), 32'hFFE);
      step(1);
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      chk("busy_start_op",   32'(ALU_op),   32'(op_lda));
      chk("busy_start_data", 32'(InData),   32'h01);
      chk("busy_start_addr", 32'(ROM_addr), 32'hFFE);
      step(1);
      chk("wrap_fetch_fff",  32'(ROM_addr), 32'hFFF);
      step(3);
      chk("wrap_fetch_000",  32'(ROM_addr), 32'h000);
      chk("wrap_busy",       32'(Busy),     32'd1);
      chk("wrap_illegal",    32'(Illegal),  32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cpu_ctrl.md
# cpu_ctrl

Control unit of the microcontroller, sitting directly upstream of `alu`. It fetches 12-bit instruction words from a synchronous program ROM and decodes them. It issues single-cycle `ALU_op`/`InData` commands, and resolves conditional jumps from the ALU flags. A multi-state fetch/decode/execute FSM with a 12-bit program counter provides the sequencing.

## Interface
Parameters:
- `PC_W`, 12, program counter / ROM address width
- `ROM_LAT`, 1, ROM read latency in cycles (fixed 1; other values unsupported)

Ports:
- `Clk`  in  1  system clock
- `Rst`  in  1  asynchronous, active-high reset
- `Start`  in  1  single-cycle pulse; leaves IDLE/HALT
- `ROM_addr`  out  PC_W  program ROM address
- `ROM_data`  in  12  instruction word, valid one cycle after `ROM_addr`
- `ALU_op`  out  alu_op  command to ALU; `nop` except in EXEC
- `InData`  out  8  immediate operand to ALU
- `FlagZ`, `FlagC`, `FlagN`, `FlagE`  in  1 each  ALU flags
- `Busy`  out  1  high in every state except IDLE/HALT
- `Halted`  out  1  high in HALT
- `Illegal`  out  1  sticky; set on undefined ALU code, cleared by reset or `Start`

## Operation
Instruction word, decoded on `IR[11:10]`:
- `00` ALU: `IR[4:0]` is the `alu_op` code; `InData` is 0. Codes outside the defined `alu_op` set issue `nop` and set `Illegal`.
- `01` LDI: `IR[8]` selects the destination (0 → `op_lda`, 1 → `op_ldb`); `IR[7:0]` drives `InData`.
- `10` JMP: `IR[9:8]` is the condition (00 always, 01 Z, 10 C, 11 N). The following word is the 12-bit target.
- `11` HLT: enter HALT.

FSM states: IDLE, FETCH, DECODE, EXEC, FETCH_T, DECODE_T, HALT.
- IDLE/HALT: `Start` → FETCH. IDLE leaves with PC = 0. HALT resumes at PC+1.
- FETCH: `ROM_addr` = PC; PC increments → DECODE.
- DECODE: `IR` ← `ROM_data`.
  - ALU/LDI → EXEC.
  - JMP → FETCH_T.
  - HLT → HALT.
- EXEC: `ALU_op`/`InData` are driven for exactly one cycle → FETCH.
- FETCH_T: `ROM_addr` = PC; PC increments → DECODE_T.
- DECODE_T: the condition is evaluated on the flags sampled this cycle.
  - Taken: PC ← `ROM_data[PC_W-1:0]`.
  - Not taken: PC is unchanged (already past the target word).
  - Next state → FETCH.

Rules:
- PC wraps from 0xFFF to 0x000 with no error.
- `InData` holds its last value outside EXEC. `ALU_op` returns to `nop`.
- `Start` outside IDLE/HALT is ignored.
- Reset mid-instruction aborts it, with no partial ALU command. All outputs go to reset values immediately.

## Timing
- Reset values:
  - `ROM_addr` = 0, `ALU_op` = `nop`, `InData` = 0.
  - `Busy` = 0, `Halted` = 0, `Illegal` = 0.
  - state = IDLE, PC = 0.
- ALU/LDI: 3 cycles (FETCH, DECODE, EXEC); throughput is one instruction per 3 cycles.
- JMP: 4 cycles, taken or not.
- HLT: 2 cycles to reach HALT. `Halted` is asserted the cycle after DECODE.
- `Start` → first `ROM_addr` valid: 1 cycle.
- Flags:
  - The ALU registers its flags on the EXEC edge.
  - A JMP immediately after an ALU instruction sees those flags in DECODE_T, at least 3 cycles later.
  - No forwarding is required.
- All outputs are registered.

## Structure
- `global_pkg` gains:
  - `ctrl_state_t` enum.
  - Instruction type constants `INS_ALU`, `INS_LDI`, `INS_JMP`, `INS_HLT`.
  - Condition constants.
- The existing `alu_op` type is reused unchanged.
- Single module; no sub-module. The condition evaluator is a local function.

## Test plan
- Reset mid-EXEC of `op_add`: `ALU_op` = `nop` and `ROM_addr` = 0 immediately. After `Start`, fetch restarts at 0.
- Program LDI A 0x03, LDI B 0x02, ALU `op_add`, ALU `op_oeacc`, HLT: ALU `OutData` = 0x05. `Halted` is high after 14 cycles. `ALU_op` is never non-`nop` outside EXEC.
- LDI A 0x05, LDI B 0x05, `op_sub`, JMP Z → 0x020: PC = 0x020 and the fetch at 0x020 follows. Repeated with 0x06/0x05: not taken, fetch continues at the word after the target.
- ALU word with an undefined code: `nop` is issued, `Illegal` = 1 and stays 1 through later instructions. `Start` after HLT clears it.
- Straight-line code placed at 0xFFE: PC wraps and fetches 0xFFF then 0x000.
- `Start` pulsed while `Busy`: no effect on PC or state.
